// File: rtl/rx_pkg.sv
// Shared types and widths for the receiver pixel path.
package rx_pkg;

  localparam int PIX_W  = 24;
  localparam int CHAN_W = 8;
  localparam int CSUM_W = 16;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, FIN} state_t;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             last;
  } pix_entry_t;

  // Sum of the three channel bytes of one packed pixel.
  function automatic logic [9:0] pix_sum(input logic [PIX_W-1:0] p);
    return 10'(p[3*CHAN_W-1:2*CHAN_W]) + 10'(p[2*CHAN_W-1:CHAN_W]) + 10'(p[CHAN_W-1:0]);
  endfunction

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head so the output is a plain register.
module pix_fifo2 #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0    <= '0;
      e1    <= '0;
      count <= '0;
    end else if (clr) begin
      e0    <= '0;
      e1    <= '0;
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = e0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/rgb_pixel_streamer.sv
// Reads the R/G/B channel memories in lockstep and streams packed pixels
// on a valid/ready interface, accumulating a byte checksum of the frame.
module rgb_pixel_streamer
  import rx_pkg::*;
#(
  parameter int NUM_PIXELS = 16384,
  parameter int ADDR_W     = $clog2(NUM_PIXELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [CHAN_W-1:0] r_data,
  input  logic [CHAN_W-1:0] g_data,
  input  logic [CHAN_W-1:0] b_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic [CSUM_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t            state;
  logic [ADDR_W-1:0] rd_ptr;
  logic              inflight;
  logic              inflight_last;
  logic [CSUM_W-1:0] csum;

  pix_entry_t        din;
  pix_entry_t        head;
  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              clr;
  logic              issue;
  logic              last_issue;
  logic [2:0]        occ;

  always_comb begin
    pop        = !fifo_empty && pix_ready;
    push       = inflight && (!fifo_full || pop);
    clr        = (state == IDLE) && start;
    // Occupancy counts the pop happening this cycle so a draining sink sees one read per cycle.
    occ        = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    issue      = (state == STREAM) && (occ < 3'd2);
    last_issue = issue && (rd_ptr == LAST_ADDR);
    din.pix    = {r_data, g_data, b_data};
    din.last   = inflight_last;
  end

  pix_fifo2 #(.W($bits(pix_entry_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      csum          <= '0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      if (pop) csum <= csum + CSUM_W'(pix_sum(head.pix));
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= STREAM;
            rd_ptr <= '0;
            csum   <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            if (last_issue) state  <= FLUSH;
            else            rd_ptr <= rd_ptr + ADDR_W'(1);
          end
        end
        FLUSH: begin
          if (pop && head.last) state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_rd_en = issue;
  assign mem_addr  = rd_ptr;
  assign pix_data  = head.pix;
  assign pix_valid = !fifo_empty;
  assign pix_last  = head.last && !fifo_empty;
  assign busy      = (state == STREAM) || (state == FLUSH);
  assign done      = (state == FIN);
  assign checksum  = csum;

endmodule

// File: tb/tb_rgb_pixel_streamer.sv
// Self-checking bench for rgb_pixel_streamer: table-driven frames on a 4-pixel
// instance plus a 100-pixel all-0xFF instance for checksum wrap.
module tb_rgb_pixel_streamer;

  localparam int N  = 4;
  localparam int NB = 100;
  localparam logic [3:0][23:0] FIX_PIX = {24'h280407, 24'h1E0380, 24'h140200, 24'h0A01FF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, pix_ready;
  logic        mem_rd_en, pix_valid, pix_last, busy, done;
  logic [1:0]  mem_addr;
  logic [7:0]  r_data, g_data, b_data;
  logic [23:0] pix_data;
  logic [15:0] checksum;

  logic        start_b, ready_b;
  logic        rd_en_b, valid_b, last_b, busy_b, done_b;
  logic [6:0]  addr_b;
  logic [23:0] data_b;
  logic [15:0] csum_b;

  rgb_pixel_streamer #(.NUM_PIXELS(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .busy(busy), .done(done), .checksum(checksum)
  );

  rgb_pixel_streamer #(.NUM_PIXELS(NB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .mem_rd_en(rd_en_b), .mem_addr(addr_b),
    .r_data(8'hFF), .g_data(8'hFF), .b_data(8'hFF),
    .pix_data(data_b), .pix_valid(valid_b), .pix_ready(ready_b),
    .pix_last(last_b), .busy(busy_b), .done(done_b), .checksum(csum_b)
  );

  // Synchronous-read channel memories: data appears the cycle after the strobe.
  logic [7:0] mr [N];
  logic [7:0] mg [N];
  logic [7:0] mb [N];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      r_data <= mr[mem_addr];
      g_data <= mg[mem_addr];
      b_data <= mb[mem_addr];
    end
  end

  typedef struct {
    int               mode;
    bit               restart;
    bit               rnd;
    logic [3:0][23:0] pix;
    logic [15:0]      csum;
  } vec_t;

  vec_t        vt [7];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc, acc, rd_issued, last_acc_cyc;
  logic [23:0] q [$];
  bit          hold_pending;
  logic [23:0] held;
  logic [15:0] exp_csum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"},  mem_rd_en, 0);
    chk({tag, "_addr"},   mem_addr,  0);
    chk({tag, "_data"},   pix_data,  0);
    chk({tag, "_valid"},  pix_valid, 0);
    chk({tag, "_last"},   pix_last,  0);
    chk({tag, "_busy"},   busy,      0);
    chk({tag, "_done"},   done,      0);
    chk({tag, "_csum"},   checksum,  0);
  endtask

  function automatic bit ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c - 1) % 3) == 0;
      2:       return c > 20;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock of the 4-pixel DUT: drive at the falling edge, observe 1 ns later.
  task automatic step(input bit rdy, input bit st);
    logic [23:0] e;
    @(negedge clk);
    pix_ready = rdy;
    start     = st;
    #1;
    cyc++;
    if (mem_rd_en) begin
      chk("rd_addr", 32'(mem_addr), 32'(rd_issued));
      rd_issued++;
    end
    if (hold_pending) begin
      chk("hold_valid", pix_valid, 1);
      chk("hold_data", pix_data, held);
    end
    chk("pix_last", pix_last, pix_valid && (acc == N - 1));
    if (pix_valid && pix_ready) begin
      e = 24'hxxxxxx;
      if (q.size() > 0) e = q.pop_front();
      chk("pixel", pix_data, e);
      acc++;
      last_acc_cyc = cyc;
    end
    chk("outstanding", (rd_issued - acc) <= 2, 1);
    hold_pending = pix_valid && !pix_ready;
    held         = pix_data;
  endtask

  task automatic load_fixed();
    mr = '{8'd10, 8'd20, 8'd30, 8'd40};
    mg = '{8'd1, 8'd2, 8'd3, 8'd4};
    mb = '{8'hFF, 8'h00, 8'h80, 8'h07};
  endtask

  task automatic load_vec(input vec_t v);
    q.delete();
    if (v.rnd) begin
      exp_csum = '0;
      for (int i = 0; i < N; i++) begin
        mr[i] = 8'($urandom);
        mg[i] = 8'($urandom);
        mb[i] = 8'($urandom);
        q.push_back({mr[i], mg[i], mb[i]});
        exp_csum = exp_csum + 16'(mr[i]) + 16'(mg[i]) + 16'(mb[i]);
      end
    end else begin
      load_fixed();
      for (int i = 0; i < N; i++) q.push_back(v.pix[i]);
      exp_csum = v.csum;
    end
  endtask

  task automatic begin_frame();
    hold_pending = 1'b0;
    acc          = 0;
    rd_issued    = 0;
    cyc          = 0;
    step(1'b0, 1'b1);
    cyc = 0;
  endtask

  task automatic run_frame(input int mode, input bit restart_mid);
    int nexp;
    nexp = q.size();
    begin_frame();
    do begin
      step(ready_for(mode, cyc + 1), restart_mid && (cyc + 1 == 5));
      if (cyc == 1) begin
        chk("busy_after_start", busy, 1);
        chk("first_rd_en", mem_rd_en, 1);
      end
      if (cyc == 2) chk("valid_c2", pix_valid, 0);
      if (cyc == 3) chk("valid_c3", pix_valid, 1);
      if (mode == 2 && cyc == 20) chk("stall_reads", rd_issued, 2);
      if (!done) chk("busy", busy, 1);
    end while (!done && cyc < 300);
    chk("done_seen", done, 1);
    chk("done_timing", cyc, last_acc_cyc + 1);
    chk("busy_at_done", busy, 0);
    chk("pix_count", acc, nexp);
    chk("queue_empty", q.size(), 0);
    chk("checksum", checksum, exp_csum);
    step(1'b0, 1'b0);
    chk("done_pulse", done, 0);
    chk("csum_hold", checksum, exp_csum);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int acc_b;
    int cb;

    vt[0] = '{mode: 0, restart: 0, rnd: 0, pix: FIX_PIX, csum: 16'h01F4};
    vt[1] = '{mode: 1, restart: 0, rnd: 0, pix: FIX_PIX, csum: 16'h01F4};
    vt[2] = '{mode: 2, restart: 0, rnd: 0, pix: FIX_PIX, csum: 16'h01F4};
    vt[3] = '{mode: 0, restart: 1, rnd: 0, pix: FIX_PIX, csum: 16'h01F4};
    vt[4] = '{mode: 3, restart: 0, rnd: 1, pix: '0, csum: '0};
    vt[5] = '{mode: 3, restart: 1, rnd: 1, pix: '0, csum: '0};
    vt[6] = '{mode: 1, restart: 0, rnd: 1, pix: '0, csum: '0};

    rst = 1'b0; start = 1'b0; pix_ready = 1'b0;
    start_b = 1'b0; ready_b = 1'b1;
    cyc = 0;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (vt[i]) begin
      load_vec(vt[i]);
      run_frame(vt[i].mode, vt[i].restart);
    end

    // Reset mid-frame after the second pixel is taken, then a clean frame.
    load_vec(vt[0]);
    begin_frame();
    do step(1'b1, 1'b0); while (acc < 2 && cyc < 50);
    chk("reached_2nd", acc, 2);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    load_vec(vt[0]);
    run_frame(0, 1'b0);

    // 100-pixel all-0xFF frame: checksum wraps modulo 2^16.
    acc_b = 0;
    cb    = 0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    #1;
    while (!done_b && cb < 400) begin
      if (rd_en_b) chk("b_addr_range", addr_b <= 7'(NB - 1), 1);
      if (valid_b) begin
        chk("b_pixel", data_b, 24'hFFFFFF);
        chk("b_last", last_b, acc_b == NB - 1);
        acc_b++;
      end
      @(negedge clk);
      #1;
      cb++;
    end
    chk("b_done_seen", done_b, 1);
    chk("b_count", acc_b, NB);
    chk("b_checksum", csum_b, 16'h2AD4);
    chk("b_busy_at_done", busy_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
